fp_add_arbiter: RTL and testbench
=================================

Name: fp_add_arbiter

Overview:
- Shares one combinational single-precision FP adder among NUM_REQ requesters.
- Round-robin arbitration; requester operands are registered into the adder; adder outputs are captured into a held response register with the requester ID.
- Sits between FPU issue ports and the shared adder instance, which is instantiated outside this block.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 3, width of requester ID; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous reset, active-low.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  one-hot grant/accept.
- req_a  input  NUM_REQ*32  operand A per requester; slice i = [32*i+:32].
- req_b  input  NUM_REQ*32  operand B per requester.
- req_rmode  input  NUM_REQ*3  rounding mode per requester.
- add_a  output  32  to adder fp_a.
- add_b  output  32  to adder fp_b.
- add_rmode  output  3  to adder r_mode.
- add_result  input  32  from adder fp_result.
- add_overflow  input  1  from adder.
- add_underflow  input  1  from adder.
- resp_valid  output  1  response valid.
- resp_ready  input  1  response consumer ready.
- resp_id  output  ID_W  requester index of response.
- resp_result  output  32  sum.
- resp_overflow  output  1  overflow flag.
- resp_underflow  output  1  underflow flag.
- resp_err  output  1  illegal r_mode.
- busy  output  1  FSM not in IDLE.
- sticky_ovf  output  1  see Optional Feature.
- sticky_unf  output  1  see Optional Feature.
- clr_sticky  input  1  clears sticky flags.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM goes to IDLE; rr_ptr=0.
  - add_a, add_b, add_rmode = 0.
  - All resp_* = 0; req_ready = 0; busy = 0; sticky flags = 0.
  - Reset mid-operation discards the in-flight op; no response is ever produced for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first requester with req_valid set, searching rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - req_ready is combinational, one-hot to the winner, asserted only in IDLE.
  - The handshake completes in that same cycle.
  - On the edge: latch winner's a, b, rmode and id into op registers.
  - If rmode is 0..4, go to EXEC.
  - If rmode is 5..7, go to RESP directly with resp_err=1, resp_result=32'h7FC00000, ovf/unf=0; the adder is not used.
- EXEC (1 cycle):
  - add_a, add_b, add_rmode are driven from op registers; they are stable for the entire EXEC cycle.
  - At the edge: resp_result <= add_result, resp_overflow <= add_overflow, resp_underflow <= add_underflow, resp_err <= 0.
  - Go to RESP.
- RESP:
  - resp_valid=1; all resp_* fields are held stable until resp_ready=1.
  - On a cycle with resp_valid & resp_ready: go to IDLE, rr_ptr <= (resp_id+1) mod NUM_REQ.
  - resp_valid drops next cycle.
  - No new grant is issued while in EXEC or RESP.
- Timing:
  - Latency: grant edge T → resp_valid visible in cycle T+2 (legal op) or T+1 (illegal rmode).
  - Max throughput is one op per 3 cycles with resp_ready held high.
- Op registers: add_* keep the last issued op values outside EXEC; they are not zeroed.
- Requester contract: a requester must keep req_valid and data stable until granted; the block does not check this.
- A requester whose req_valid drops before grant simply loses its turn; no state change results.
- busy = (state != IDLE).

Optional Feature:
- Macro: FP_ADD_ARB_STICKY_EN.
- Defined:
  - sticky_ovf/sticky_unf set on the RESP handshake cycle when resp_overflow/resp_underflow is 1.
  - They stay set until clr_sticky=1 or reset.
  - If clr_sticky and a set event occur in the same cycle, set wins.
- Undefined: sticky_ovf/sticky_unf are tied to 0; clr_sticky is ignored.

Test Plan:
- Basic add: req0 a=32'h3F800000, b=32'h3F800000, rmode=3'b001, resp_ready=1 → req_ready=4'b0001 in cycle T; resp_valid at T+2 with resp_id=0, resp_result=32'h40000000, overflow=0, underflow=0.
- Round-robin: req_valid=4'b0101 held, resp_ready=1 → grant sequence 0,2,0,2; each grant is 3 cycles apart.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid → resp_valid and resp_result are stable for all 5 cycles; req_ready=0 throughout; next grant comes only after the handshake.
- Illegal mode: req1 rmode=3'b101 → resp_valid at T+1 with resp_id=1, resp_err=1, resp_result=32'h7FC00000; add_a unchanged.
- Sticky (macro on): adder model returns add_overflow=1 for a=b=32'h7F7FFFFF, rmode=000 → resp_overflow=1; sticky_ovf=1 after the handshake; clr_sticky pulse → 0. With macro off, sticky_ovf stays 0.
- Reset mid-op: assert rst_n=0 during EXEC → next cycle state IDLE, resp_valid=0, add_a=0, rr_ptr=0; no response is ever emitted for that op.

Source files
------------

// File: rtl/fp_add_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_arbiter
//  Description : Round-robin arbiter that shares one external combinational
//                single-precision FP adder among NUM_REQ requesters.
//                The winner's operands are registered toward the adder. The
//                adder result is captured into a held response register
//                that is tagged with the requester ID.
//                Optional sticky overflow/underflow flags are compiled in
//                when FP_ADD_ARB_STICKY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*32-1:0]  req_a,
  input  logic [NUM_REQ*32-1:0]  req_b,
  input  logic [NUM_REQ*3-1:0]   req_rmode,
  output logic [31:0]            add_a,
  output logic [31:0]            add_b,
  output logic [2:0]             add_rmode,
  input  logic [31:0]            add_result,
  input  logic                   add_overflow,
  input  logic                   add_underflow,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [31:0]            resp_result,
  output logic                   resp_overflow,
  output logic                   resp_underflow,
  output logic                   resp_err,
  output logic                   busy,
  output logic                   sticky_ovf,
  output logic                   sticky_unf,
  input  logic                   clr_sticky
);

  // Canonical quiet NaN returned for an illegal rounding mode
  localparam logic [31:0] c_QNAN     = 32'h7FC0_0000;
  localparam logic [2:0]  c_RMODE_MAX = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [31:0]       r_add_a;
  logic [31:0]       r_add_b;
  logic [2:0]        r_add_rmode;
  logic              r_resp_valid;
  logic [ID_W-1:0]   r_resp_id;
  logic [31:0]       r_resp_result;
  logic              r_resp_overflow;
  logic              r_resp_underflow;
  logic              r_resp_err;

  logic              w_found;
  logic [ID_W-1:0]   w_win_id;
  logic [31:0]       w_sel_a;
  logic [31:0]       w_sel_b;
  logic [2:0]        w_sel_rmode;
  logic              w_legal;
  logic              w_resp_hs;
  logic [ID_W-1:0]   w_next_ptr;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping
  always_comb begin
    w_found  = 1'b0;
    w_win_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!w_found && req_valid[j] &&
            (j == ((int'(r_rr_ptr) + k) % NUM_REQ))) begin
          w_found  = 1'b1;
          w_win_id = ID_W'(j);
        end
      end
    end
  end

  // Select the winner's operand slices
  always_comb begin
    w_sel_a     = '0;
    w_sel_b     = '0;
    w_sel_rmode = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win_id == ID_W'(i)) begin
        w_sel_a     = req_a[32*i +: 32];
        w_sel_b     = req_b[32*i +: 32];
        w_sel_rmode = req_rmode[3*i +: 3];
      end
    end
  end

  // One-hot grant, only offered while idle and out of reset
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = rst_n && (r_state == S_IDLE) && w_found &&
                     (w_win_id == ID_W'(i));
    end
  end

  assign w_legal    = (w_sel_rmode <= c_RMODE_MAX);
  assign w_resp_hs  = r_resp_valid && resp_ready;
  // Next search starts just after the requester that was served
  assign w_next_ptr = (r_resp_id == ID_W'(NUM_REQ - 1)) ? '0
                                                         : r_resp_id + ID_W'(1);

  // Control FSM with registered adder operands and held response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_rr_ptr         <= '0;
      r_add_a          <= '0;
      r_add_b          <= '0;
      r_add_rmode      <= '0;
      r_resp_valid     <= 1'b0;
      r_resp_id        <= '0;
      r_resp_result    <= '0;
      r_resp_overflow  <= 1'b0;
      r_resp_underflow <= 1'b0;
      r_resp_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_resp_id <= w_win_id;
            if (w_legal) begin
              // Adder operands only change when the adder is really used
              r_add_a     <= w_sel_a;
              r_add_b     <= w_sel_b;
              r_add_rmode <= w_sel_rmode;
              r_state     <= S_EXEC;
            end else begin
              // Illegal rounding mode: answer immediately, bypass the adder
              r_resp_result    <= c_QNAN;
              r_resp_overflow  <= 1'b0;
              r_resp_underflow <= 1'b0;
              r_resp_err       <= 1'b1;
              r_resp_valid     <= 1'b1;
              r_state          <= S_RESP;
            end
          end
        end
        S_EXEC: begin
          r_resp_result    <= add_result;
          r_resp_overflow  <= add_overflow;
          r_resp_underflow <= add_underflow;
          r_resp_err       <= 1'b0;
          r_resp_valid     <= 1'b1;
          r_state          <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_rr_ptr     <= w_next_ptr;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign add_a          = r_add_a;
  assign add_b          = r_add_b;
  assign add_rmode      = r_add_rmode;
  assign resp_valid     = r_resp_valid;
  assign resp_id        = r_resp_id;
  assign resp_result    = r_resp_result;
  assign resp_overflow  = r_resp_overflow;
  assign resp_underflow = r_resp_underflow;
  assign resp_err       = r_resp_err;
  assign busy           = (r_state != S_IDLE);

`ifdef FP_ADD_ARB_STICKY_EN
  logic r_sticky_ovf;
  logic r_sticky_unf;

  // Accumulate flags seen at response handshake; a set beats a clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sticky_ovf <= 1'b0;
      r_sticky_unf <= 1'b0;
    end else begin
      if (w_resp_hs && r_resp_overflow) begin
        r_sticky_ovf <= 1'b1;
      end else if (clr_sticky) begin
        r_sticky_ovf <= 1'b0;
      end
      if (w_resp_hs && r_resp_underflow) begin
        r_sticky_unf <= 1'b1;
      end else if (clr_sticky) begin
        r_sticky_unf <= 1'b0;
      end
    end
  end

  assign sticky_ovf = r_sticky_ovf;
  assign sticky_unf = r_sticky_unf;
`else
  // Sticky flags compiled out; the clear input has no effect
  logic w_unused_sticky;
  assign w_unused_sticky = clr_sticky ^ w_resp_hs;
  assign sticky_ovf      = 1'b0;
  assign sticky_unf      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_add_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_add_arbiter
//  Description : Self-checking bench for fp_add_arbiter with a stand-in
//                adder and a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_add_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 3;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ*3-1:0]  req_rmode;
  logic [31:0]           add_a;
  logic [31:0]           add_b;
  logic [2:0]            add_rmode;
  logic [31:0]           add_result;
  logic                  add_overflow;
  logic                  add_underflow;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_result;
  logic                  resp_overflow;
  logic                  resp_underflow;
  logic                  resp_err;
  logic                  busy;
  logic                  sticky_ovf;
  logic                  sticky_unf;
  logic                  clr_sticky;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference-model state
  int          m_ptr;
  logic [31:0] m_add_a;
  logic [31:0] m_add_b;
  logic [2:0]  m_add_rm;
  logic        m_sovf;
  logic        m_sunf;

  fp_add_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_a          (req_a),
    .req_b          (req_b),
    .req_rmode      (req_rmode),
    .add_a          (add_a),
    .add_b          (add_b),
    .add_rmode      (add_rmode),
    .add_result     (add_result),
    .add_overflow   (add_overflow),
    .add_underflow  (add_underflow),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_id        (resp_id),
    .resp_result    (resp_result),
    .resp_overflow  (resp_overflow),
    .resp_underflow (resp_underflow),
    .resp_err       (resp_err),
    .busy           (busy),
    .sticky_ovf     (sticky_ovf),
    .sticky_unf     (sticky_unf),
    .clr_sticky     (clr_sticky)
  );

  always #5 clk = ~clk;

  // Stand-in for the external adder: deterministic, distinguishable results
  function automatic logic [31:0] adder_sum(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] rm);
    if (a == 32'h3F80_0000 && b == 32'h3F80_0000) return 32'h4000_0000;
    return (a + b) ^ {29'd0, rm};
  endfunction

  function automatic logic adder_ovf(input logic [31:0] a, input logic [31:0] b);
    return ({1'b0, a[30:23]} + {1'b0, b[30:23]}) > 9'd300;
  endfunction

  function automatic logic adder_unf(input logic [31:0] a, input logic [31:0] b);
    return ({1'b0, a[30:23]} + {1'b0, b[30:23]}) < 9'd100;
  endfunction

  assign add_result    = adder_sum(add_a, add_b, add_rmode);
  assign add_overflow  = adder_ovf(add_a, add_b);
  assign add_underflow = adder_unf(add_a, add_b);

  // Expected winner: first valid requester scanning from the pointer
  function automatic int pick(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance one clock; the model sees the same clr_sticky the DUT samples
  task automatic next_cycle(input bit hs, input bit ovf, input bit unf);
    @(posedge clk);
`ifdef FP_ADD_ARB_STICKY_EN
    if (hs && ovf) m_sovf = 1'b1; else if (clr_sticky) m_sovf = 1'b0;
    if (hs && unf) m_sunf = 1'b1; else if (clr_sticky) m_sunf = 1'b0;
`else
    if (hs && (ovf || unf)) m_sovf = 1'b0;
`endif
    @(negedge clk);
  endtask

  // One full request/response transaction, called at a negedge with DUT idle
  task automatic run_txn(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ*32-1:0] a,
                         input logic [NUM_REQ*32-1:0] b, input logic [NUM_REQ*3-1:0] rm,
                         input int stall, input bit rnd_clr);
    int          w;
    logic [31:0] ea, eb, eres;
    logic [2:0]  erm;
    bit          legal, eovf, eunf, eerr;
    req_valid  = v;
    req_a      = a;
    req_b      = b;
    req_rmode  = rm;
    resp_ready = (stall == 0);
    clr_sticky = rnd_clr && ($urandom_range(0, 3) == 0);
    #1;
    w = pick(v, m_ptr);
    chk("idle_resp_valid", resp_valid, 0);
    chk("idle_busy", busy, 0);
    chk("sticky_ovf", sticky_ovf, m_sovf);
    chk("sticky_unf", sticky_unf, m_sunf);
    if (w < 0) begin
      chk("req_ready_none", req_ready, 0);
      next_cycle(0, 0, 0);
      return;
    end
    chk("req_ready_grant", req_ready, 32'd1 << w);
    ea    = a[32*w +: 32];
    eb    = b[32*w +: 32];
    erm   = rm[3*w +: 3];
    legal = (erm <= 3'd4);
    if (legal) begin
      eres = adder_sum(ea, eb, erm);
      eovf = adder_ovf(ea, eb);
      eunf = adder_unf(ea, eb);
      eerr = 1'b0;
    end else begin
      eres = 32'h7FC0_0000;
      eovf = 1'b0;
      eunf = 1'b0;
      eerr = 1'b1;
    end
    next_cycle(0, 0, 0);
    if (legal) begin
      req_valid  = NUM_REQ'($urandom_range(0, 15));
      clr_sticky = rnd_clr && ($urandom_range(0, 3) == 0);
      #1;
      m_add_a  = ea;
      m_add_b  = eb;
      m_add_rm = erm;
      chk("exec_busy", busy, 1);
      chk("exec_resp_valid", resp_valid, 0);
      chk("exec_req_ready", req_ready, 0);
      chk("exec_add_a", add_a, ea);
      chk("exec_add_b", add_b, eb);
      chk("exec_add_rmode", add_rmode, erm);
      next_cycle(0, 0, 0);
    end
    for (int s = 0; s <= stall; s++) begin
      req_valid  = NUM_REQ'($urandom_range(0, 15));
      resp_ready = (s == stall);
      clr_sticky = rnd_clr && ($urandom_range(0, 3) == 0);
      #1;
      chk("resp_valid", resp_valid, 1);
      chk("resp_id", resp_id, w);
      chk("resp_result", resp_result, eres);
      chk("resp_overflow", resp_overflow, eovf);
      chk("resp_underflow", resp_underflow, eunf);
      chk("resp_err", resp_err, eerr);
      chk("resp_req_ready", req_ready, 0);
      chk("resp_busy", busy, 1);
      chk("resp_add_a", add_a, m_add_a);
      chk("sticky_ovf_resp", sticky_ovf, m_sovf);
      next_cycle(s == stall, eovf, eunf);
    end
    m_ptr = (w + 1) % NUM_REQ;
  endtask

  task automatic clear_pulse();
    req_valid  = '0;
    clr_sticky = 1'b1;
    next_cycle(0, 0, 0);
    clr_sticky = 1'b0;
  endtask

  logic [NUM_REQ*32-1:0] ta, tb;
  logic [NUM_REQ*3-1:0]  trm;

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_rmode  = '0;
    resp_ready = 1'b0;
    clr_sticky = 1'b0;
    m_ptr      = 0;
    m_add_a    = '0;
    m_add_b    = '0;
    m_add_rm   = '0;
    m_sovf     = 1'b0;
    m_sunf     = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_add_rmode", add_rmode, 0);
    chk("rst_resp_result", resp_result, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_sticky_ovf", sticky_ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add: 1.0 + 1.0 from requester 0
    ta = '0; tb = '0; trm = '0;
    ta[31:0] = 32'h3F80_0000;
    tb[31:0] = 32'h3F80_0000;
    trm[2:0] = 3'b001;
    run_txn(4'b0001, ta, tb, trm, 0, 0);

    // Round-robin between requesters 0 and 2, back-to-back
    ta  = {$urandom, $urandom, $urandom, $urandom};
    tb  = {$urandom, $urandom, $urandom, $urandom};
    trm = 12'b000_001_000_010;
    for (int i = 0; i < 4; i++) run_txn(4'b0101, ta, tb, trm, 0, 0);

    // Backpressure: five stalled response cycles
    run_txn(4'b1111, ta, tb, trm, 5, 0);

    // Illegal rounding mode on requester 1
    trm = 12'b000_000_101_000;
    run_txn(4'b0010, ta, tb, trm, 0, 0);

    // Overflow feeds the sticky flag, then a clear pulse
    ta = '0; tb = '0; trm = '0;
    ta[127:96] = 32'h7F7F_FFFF;
    tb[127:96] = 32'h7F7F_FFFF;
    run_txn(4'b1000, ta, tb, trm, 1, 0);
    req_valid = '0;
    #1;
    chk("sticky_ovf_after_hs", sticky_ovf, m_sovf);
    clear_pulse();
    #1;
    chk("sticky_ovf_after_clr", sticky_ovf, 0);

    // Randomized traffic with random stalls and clear pulses
    for (int n = 0; n < 60; n++) begin
      ta  = {$urandom, $urandom, $urandom, $urandom};
      tb  = {$urandom, $urandom, $urandom, $urandom};
      trm = 12'($urandom);
      run_txn(NUM_REQ'($urandom_range(0, 15)), ta, tb, trm, $urandom_range(0, 3), 1);
    end
    clr_sticky = 1'b0;

    // Reset in the middle of an operation
    trm = '0;
    run_txn(4'b0100, ta, tb, trm, 0, 0);
    req_valid  = 4'b1000;
    resp_ready = 1'b1;
    next_cycle(0, 0, 0);
    req_valid = '0;
    #1;
    chk("midop_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_add_a", add_a, 0);
    chk("midrst_sticky", sticky_ovf, 0);
    rst_n    = 1'b1;
    m_ptr    = 0;
    m_add_a  = '0;
    m_add_b  = '0;
    m_add_rm = '0;
    m_sovf   = 1'b0;
    m_sunf   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle(0, 0, 0);
      #1;
      chk("no_resp_after_rst", resp_valid, 0);
    end
    // Pointer restarts at 0
    ta  = {$urandom, $urandom, $urandom, $urandom};
    tb  = {$urandom, $urandom, $urandom, $urandom};
    run_txn(4'b1111, ta, tb, trm, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound in case the run stalls
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
